// File: rtl/lsu_mem_if_pkg.sv
// Shared core constants and types for the load/store unit.
package lsu_mem_if_pkg;

  // Major opcodes (instr[6:2]) handled by the LSU
  localparam logic [4:0] LOAD  = 5'b00000;
  localparam logic [4:0] STORE = 5'b01000;

  typedef enum logic [2:0] {
    LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3,
    LBU = 3'd4, LHU = 3'd5, LWU = 3'd6
  } ld_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'd0, SH = 3'd1, SW = 3'd2, SD = 3'd3
  } st_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // size is log2(bytes); off is the low address bits
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store replication/strobes and load extraction/extension.
module lsu_align
  import lsu_mem_if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            rs2_data,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic [XLEN-1:0]            wdata,
  output logic [XLEN/8-1:0]          wstrb,
  output logic [XLEN-1:0]            ldata
);
  localparam int NB = XLEN / 8;

  logic [1:0]      size;
  logic [NB-1:0]   smask;
  logic [XLEN-1:0] rsh;
  int              nbits;

  assign size = funct3[1:0];

  // Replicate store data into every lane, build strobes, extract and extend load data
  always_comb begin
    wdata = '0;
    smask = '0;
    rsh   = mem_rdata >> {offset, 3'b000};
    nbits = ((8 << size) > XLEN) ? XLEN : (8 << size);
    for (int i = 0; i < NB; i++) begin
      wdata[8*i +: 8] = rs2_data[8*(i % (1 << size)) +: 8];
      smask[i]        = (i < (1 << size));
    end
    wstrb = smask << offset;
    ldata = rsh;
    for (int i = 0; i < XLEN; i++)
      if (i >= nbits) ldata[i] = ~funct3[2] & rsh[nbits-1];
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: single-outstanding req/ack bus access with core stall.
// Optional LSU_BUS_TIMEOUT_EN: abort a BUS wait after TIMEOUT ack-less cycles.
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:2]       instr,
  input  logic              instr_valid,
  input  logic [XLEN-1:0]   ieu_result,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   lsu_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  lsu_state_t      state, state_nxt;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, ld_ok, st_ok, mem_op, mis, issue, timeout;
  logic [2:0]      f3_q;
  logic [OB-1:0]   off_q;
  logic            ld_q;
  logic [XLEN-1:0] lsu_q, al_wdata, al_ldata;
  logic [NB-1:0]   al_wstrb;
  logic [2:0]      al_f3;
  logic [OB-1:0]   al_off;
  logic            unused_ok;

  assign opcode   = instr[6:2];
  assign funct3   = instr[14:12];
  assign is_load  = (opcode == LOAD);
  assign is_store = (opcode == STORE);
  assign unused_ok = ^{instr[31:15], instr[11:7]};

  // Legal funct3 per opcode; 64-bit forms only exist when XLEN is 64
  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (funct3)
      LB, LH, LW, LBU, LHU: ld_ok = 1'b1;
      LD, LWU:              ld_ok = (XLEN == 64);
      default:              ld_ok = 1'b0;
    endcase
    case (funct3)
      SB, SH, SW: st_ok = 1'b1;
      SD:         st_ok = (XLEN == 64);
      default:    st_ok = 1'b0;
    endcase
  end

  assign mem_op = instr_valid && ((is_load && ld_ok) || (is_store && st_ok));
  assign mis    = is_misaligned(funct3[1:0], ieu_result[2:0]);

  // Stores use the live instruction in IDLE; loads extract with the captured op in BUS
  assign al_f3  = (state == IDLE) ? funct3 : f3_q;
  assign al_off = (state == IDLE) ? ieu_result[OB-1:0] : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (al_f3),
    .offset    (al_off),
    .rs2_data  (rs2_data),
    .mem_rdata (mem_rdata),
    .wdata     (al_wdata),
    .wstrb     (al_wstrb),
    .ldata     (al_ldata)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;

  assign timeout = (state == BUS) && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));
  assign bus_err = bus_err_q;

  // Ack-wait counter: zero outside BUS, counts ack-less BUS cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (state != BUS)  tmo_cnt <= '0;
      else if (!mem_ack) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
  assign timeout    = 1'b0;
  assign bus_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; DONE never re-decodes so an instruction issues once
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUS;
      BUS:     if (mem_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs: stall the core while an access is pending
  always_comb begin
    issue      = 1'b0;
    misaligned = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        issue      = mem_op && !mis;
        misaligned = mem_op && mis;
        stall      = mem_op && !mis;
      end
      BUS:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign lsu_data = misaligned ? '0 : lsu_q;

  // Bus request/data registers and load result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      lsu_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      ld_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          mem_req   <= 1'b1;
          mem_we    <= is_store;
          mem_addr  <= {ieu_result[XLEN-1:OB], {OB{1'b0}}};
          mem_wstrb <= is_store ? al_wstrb : '0;
          mem_wdata <= is_store ? al_wdata : '0;
          f3_q      <= funct3;
          off_q     <= ieu_result[OB-1:0];
          ld_q      <= is_load;
        end
        BUS: if (mem_ack) begin
          mem_req <= 1'b0;
          if (ld_q) lsu_q <= al_ldata;
        end else if (timeout) begin
          mem_req <= 1'b0;
          lsu_q   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if (XLEN=32, TIMEOUT=4).
module tb_lsu_mem_if;
  localparam logic [4:0] OP_LOAD = 5'b00000, OP_STORE = 5'b01000;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] data; logic err; logic chk_data; } rsp_t;

  logic        clk = 0, rst = 1;
  logic [31:2] instr = '0;
  logic        instr_valid = 0;
  logic [31:0] ieu_result = '0, rs2_data = '0, mem_rdata = '0;
  logic        mem_ack;
  logic [31:0] lsu_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        stall, misaligned, bus_err, mem_req, mem_we;

  int errors = 0, checks = 0, req_count = 0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   exp_mis[$];
  int   ack_dly = 0;
  logic ack_en = 1, ack_force = 0;

  lsu_mem_if #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .ieu_result(ieu_result), .rs2_data(rs2_data), .lsu_data(lsu_data),
    .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: ack after ack_dly waiting cycles
  initial begin
    int wcnt = 0;
    mem_ack = 0;
    forever begin
      @(negedge clk);
      if (ack_force) mem_ack = 1;
      else if (mem_req && ack_en) begin
        if (wcnt >= ack_dly) begin mem_ack = 1; wcnt = 0; end
        else begin mem_ack = 0; wcnt++; end
      end else begin
        mem_ack = 0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pop expectations when the DUT presents a request, a completion or a misaligned pulse
  initial begin
    logic req_d = 0, stall_d = 0, rst_d = 1;
    req_t e, snap;
    rsp_t r;
    int   m;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && !req_d) begin
        req_count++;
        if (exp_req.size() == 0) check("unexpected_req", 1, 0);
        else begin
          e = exp_req.pop_front();
          check("req_we", mem_we, e.we);
          check("req_addr", mem_addr, e.addr);
          check("req_wstrb", mem_wstrb, e.wstrb);
          check("req_wdata", mem_wdata, e.wdata);
          snap = '{mem_we, mem_addr, mem_wstrb, mem_wdata};
        end
      end else if (!rst && mem_req && req_d) begin
        check("req_stable", (mem_we == snap.we && mem_addr == snap.addr &&
               mem_wstrb == snap.wstrb && mem_wdata == snap.wdata), 1);
      end
      if (!rst && !rst_d && stall_d && !stall) begin
        if (exp_rsp.size() == 0) check("unexpected_done", 1, 0);
        else begin
          r = exp_rsp.pop_front();
          check("done_bus_err", bus_err, r.err);
          if (r.chk_data) check("done_lsu_data", lsu_data, r.data);
        end
      end
      if (misaligned) begin
        if (exp_mis.size() == 0) check("unexpected_mis", 1, 0);
        else begin
          m = exp_mis.pop_front();
          check("mis_lsu_data", lsu_data, 0);
          check("mis_stall", stall, 0);
        end
      end
      req_d = mem_req; stall_d = stall; rst_d = rst;
    end
  end

  // Present one instruction and hold it until the core would advance
  task automatic issue(input logic [4:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] rd, input int dly, output int nstall);
    logic [31:0] ins;
    logic s, done;
    ins = {17'b0, f3, 5'b0, opc, 2'b11};
    instr = ins[31:2]; instr_valid = 1; ieu_result = addr; rs2_data = rs2;
    mem_rdata = rd; ack_dly = dly; nstall = 0; done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); s = stall;
      @(posedge clk); #1;
      if (!s) begin done = 1; break; end
      nstall++;
    end
    if (!done) check("issue_bounded", 0, 1);
    instr_valid = 0;
  endtask

  initial begin
    int n, rc;
    logic [31:0] ins;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_lsu_data", lsu_data, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall", stall, 0);
    @(posedge clk); #1 rst = 0;

    // LB sign-extends top byte
    exp_req.push_back('{1'b0, 32'h1000, 4'h0, 32'h0});
    exp_rsp.push_back('{32'hFFFFFF80, 1'b0, 1'b1});
    issue(OP_LOAD, 3'd0, 32'h1003, 32'h0, 32'h8000_0000, 0, n);
    check("lb_stall_cycles", n, 2);

    // LHU zero-extends upper half
    exp_req.push_back('{1'b0, 32'h2000, 4'h0, 32'h0});
    exp_rsp.push_back('{32'h0000BEEF, 1'b0, 1'b1});
    issue(OP_LOAD, 3'd5, 32'h2002, 32'h0, 32'hBEEF_0000, 1, n);
    check("lhu_stall_cycles", n, 3);

    // LH misaligned
    rc = req_count;
    exp_mis.push_back(1);
    issue(OP_LOAD, 3'd1, 32'h2001, 32'h0, 32'h0, 0, n);
    check("lh_mis_stall", n, 0);
    check("lh_mis_noreq", req_count, rc);

    // SB with 5 ack-less cycles
    exp_req.push_back('{1'b1, 32'h3000, 4'b0010, 32'h78787878});
    exp_rsp.push_back('{32'h0, 1'b0, 1'b0});
    issue(OP_STORE, 3'd0, 32'h3001, 32'h12345678, 32'h0, 5, n);
    check("sb_stall_cycles", n, 7);

    // SH upper half
    exp_req.push_back('{1'b1, 32'h5000, 4'b1100, 32'hBEEFBEEF});
    exp_rsp.push_back('{32'h0, 1'b0, 1'b0});
    issue(OP_STORE, 3'd1, 32'h5002, 32'h0000BEEF, 32'h0, 2, n);
    check("sh_stall_cycles", n, 4);

    // LB positive byte
    exp_req.push_back('{1'b0, 32'h6000, 4'h0, 32'h0});
    exp_rsp.push_back('{32'h0000007F, 1'b0, 1'b1});
    issue(OP_LOAD, 3'd0, 32'h6001, 32'h0, 32'h0000_7F00, 0, n);

    // LW misaligned
    rc = req_count;
    exp_mis.push_back(1);
    issue(OP_LOAD, 3'd2, 32'h7002, 32'h0, 32'h0, 0, n);
    check("lw_mis_noreq", req_count, rc);

    // LD is undefined at XLEN=32: no-op
    rc = req_count;
    issue(OP_LOAD, 3'd3, 32'h7000, 32'h0, 32'h0, 0, n);
    check("ld32_stall", n, 0);
    check("ld32_noreq", req_count, rc);

    // Back-to-back LW then SW
    rc = req_count;
    exp_req.push_back('{1'b0, 32'h4000, 4'h0, 32'h0});
    exp_rsp.push_back('{32'hCAFEF00D, 1'b0, 1'b1});
    exp_req.push_back('{1'b1, 32'h4004, 4'hF, 32'hA5A5A5A5});
    exp_rsp.push_back('{32'h0, 1'b0, 1'b0});
    issue(OP_LOAD, 3'd2, 32'h4000, 32'h0, 32'hCAFEF00D, 0, n);
    issue(OP_STORE, 3'd2, 32'h4004, 32'hA5A5A5A5, 32'h0, 0, n);
    check("b2b_req_count", req_count - rc, 2);
    check("b2b_lsu_hold", lsu_data, 32'hCAFEF00D);

`ifdef LSU_BUS_TIMEOUT_EN
    // No ack: abort after 4 BUS cycles
    ack_en = 0;
    exp_req.push_back('{1'b0, 32'h9000, 4'h0, 32'h0});
    exp_rsp.push_back('{32'h0, 1'b1, 1'b1});
    issue(OP_LOAD, 3'd2, 32'h9000, 32'h0, 32'h1234_5678, 0, n);
    check("tmo_stall_cycles", n, 5);
    @(negedge clk);
    check("tmo_idle_stall", stall, 0);
    check("tmo_err_pulse", bus_err, 0);
    ack_en = 1;
`endif

    // Reset while waiting in BUS; a late ack is ignored
    ack_en = 0;
    exp_req.push_back('{1'b0, 32'h8000, 4'h0, 32'h0});
    ins = {17'b0, 3'd2, 5'b0, OP_LOAD, 2'b11};
    instr = ins[31:2]; instr_valid = 1; ieu_result = 32'h8000;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0; instr_valid = 0;
    @(negedge clk);
    check("rstbus_mem_req", mem_req, 0);
    check("rstbus_stall", stall, 0);
    check("rstbus_lsu_data", lsu_data, 0);
    mem_rdata = 32'hFFFF_FFFF; ack_force = 1;
    @(posedge clk); #1 ack_force = 0;
    @(negedge clk);
    @(negedge clk);
    check("late_ack_lsu_data", lsu_data, 0);
    check("late_ack_stall", stall, 0);
    check("late_ack_req", mem_req, 0);
    ack_en = 1;

    repeat (2) @(posedge clk);
    check("req_q_empty", exp_req.size(), 0);
    check("rsp_q_empty", exp_rsp.size(), 0);
    check("mis_q_empty", exp_mis.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
